exagu_burst_sched: RTL
======================

// Module: exagu_burst_sched
// PURPOSE
//  Arbitrates two requesters (A, B) for one scaled-index address generator.
//  Each request describes a burst: Addr[k] = Base + ((Index+k) << Scale), k = 0..Count-1.
//  The block sequences the burst one address per accepted output beat.
//  It sits between decode/issue (multi-element load/store ops) and the memory-access stage.
// PARAMETERS
//  CNT_W   8   width of burst element count
// PORTS
//  clock        in   1      core clock; all state on rising edge
//  reset        in   1      asynchronous, active-low reset
//  reqX_valid   in   1      (X=A,B) request present
//  reqX_ready   out  1      (X=A,B) request accepted this cycle
//  reqX_base    in   48     (X=A,B) base address (Rm)
//  reqX_index   in   48     (X=A,B) starting index (Ri), unscaled
//  reqX_count   in   CNT_W  (X=A,B) number of elements, 0 = null request
//  reqX_scale   in   2      (X=A,B) index shift: 0=B, 1=W, 2=L, 3=Q
//  reqX_jq      in   1      (X=A,B) 1 = 48-bit address; 0 = bits[47:32] forced to 0
//  out_valid    out  1      out_addr holds a valid element address
//  out_ready    in   1      consumer takes the beat
//  out_addr     out  48     element address
//  out_src      out  1      0 = burst owned by A, 1 = owned by B
//  out_last     out  1      beat is the final element of the burst
//  busy         out  1      state is RUN
// BEHAVIOUR
//  Reset (async, reset low):
//   - state=IDLE, rr=0 (A preferred).
//   - out_valid, out_last, out_src, busy, reqA_ready, reqB_ready = 0; out_addr = 0.
//   - A reset asserted mid-burst aborts the burst; no further beats are issued.
//  IDLE:
//   - Grant: if only one reqX_valid, grant X. If both, grant A when rr=0, else B.
//   - reqX_ready is combinational and high only for the granted X, only in IDLE.
//   - On valid&&ready, latch base, index, count, scale, jq and src.
//   - If count==0: drop the request, emit no beat, stay IDLE, set rr = ~src.
//   - Otherwise: go to RUN, set rem=count, idx=index.
//   - Register out_addr from the latched fields; out_valid=1 from the next cycle.
//   - Latency is 1 cycle from accept to first beat.
//  RUN:
//   - reqA_ready = reqB_ready = 0. out_valid=1, out_last=(rem==1).
//   - out_addr, out_src and out_last are held stable while out_ready=0.
//   - On out_valid&&out_ready with rem>1:
//     - idx += 1 (48-bit wrap); rem -= 1.
//     - out_addr = Base + (idx_next << Scale), registered, so the next beat follows back-to-back.
//   - On out_valid&&out_ready with rem==1:
//     - go to IDLE; out_valid=0, out_last=0 next cycle; rr = ~src.
//     - The next request may be accepted in that IDLE cycle, so there is a 1-cycle bubble between bursts.
//  Arithmetic:
//   - (idx << Scale) is truncated to 48 bits; the sum is modulo 2^48, carry-out discarded.
//   - jq=0: addr[47:32] = 16'h0000; bits [31:0] are the low 32 bits of the full sum.
//   - Index increments by 1 per element regardless of Scale (Scale is applied only in the address).
//   - count = 2^CNT_W-1 is a legal maximum.
//  Input changes on reqX_* outside the accept cycle have no effect on a running burst.
// TESTING
//  1. A: base=0x1000, index=2, count=3, scale=2, jq=1, out_ready=1
//     -> beats 0x1008, 0x100C, 0x1010; out_last only on the 3rd beat; out_src=0.
//  2. A and B valid in the same cycle after reset
//     -> A granted first, B granted in the first IDLE cycle after A's last beat.
//     Then both valid again -> B is NOT favoured, A served (rr toggles per completed burst).
//  3. B: base=0x0000_FFFF_FFF0, index=1, count=2, scale=3, jq=0 -> 0x0000_FFFF_FFF8, then 0x0000_0000_0000.
//     Same request with jq=1 -> 0x0000_FFFF_FFF8, then 0x0001_0000_0000.
//  4. out_ready held low for 5 cycles mid-burst -> out_addr/out_last unchanged, no element skipped or duplicated.
//  5. count=0 on A -> reqA_ready pulses once, no out_valid, rr=1.
//     Reset driven low during beat 2 of a 4-beat burst -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/exagu_burst_sched.sv
// Two-requester burst scheduler around one scaled-index address generator.
// Emits Base + ((Index+k) << Scale) per accepted beat, round-robin between bursts.
module exagu_burst_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqA_valid,
    output logic             reqA_ready,
    input  logic [47:0]      reqA_base,
    input  logic [47:0]      reqA_index,
    input  logic [CNT_W-1:0] reqA_count,
    input  logic [1:0]       reqA_scale,
    input  logic             reqA_jq,
    input  logic             reqB_valid,
    output logic             reqB_ready,
    input  logic [47:0]      reqB_base,
    input  logic [47:0]      reqB_index,
    input  logic [CNT_W-1:0] reqB_count,
    input  logic [1:0]       reqB_scale,
    input  logic             reqB_jq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      out_addr,
    output logic             out_src,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic             rr_q;
    logic [47:0]      base_q;
    logic [47:0]      idx_q;
    logic [CNT_W-1:0] rem_q;
    logic [1:0]       scale_q;
    logic             jq_q;
    logic             src_q;
    logic [47:0]      addr_q;
    logic             valid_q;
    logic             last_q;

    logic             grant_a;
    logic             grant_b;
    logic             accept;
    logic             sel_src;
    logic [47:0]      sel_base;
    logic [47:0]      sel_index;
    logic [CNT_W-1:0] sel_count;
    logic [1:0]       sel_scale;
    logic             sel_jq;
    logic [47:0]      idx_d;
    logic [CNT_W-1:0] rem_d;

    function automatic logic [47:0] calc_addr(input logic [47:0] b, input logic [47:0] i,
                                              input logic [1:0] s, input logic jq);
        logic [47:0] sum;
        sum = b + (i << s);
        if (!jq)
            sum[47:32] = '0;
        return sum;
    endfunction

    // Readies are gated by reset so nothing looks accepted while reset is held.
    always_comb begin
        grant_a    = reqA_valid && (!reqB_valid || !rr_q);
        grant_b    = reqB_valid && (!reqA_valid || rr_q);
        reqA_ready = reset && (state_q == IDLE) && grant_a;
        reqB_ready = reset && (state_q == IDLE) && grant_b;
        accept     = reqA_ready || reqB_ready;
        sel_src    = reqB_ready;
        sel_base   = sel_src ? reqB_base  : reqA_base;
        sel_index  = sel_src ? reqB_index : reqA_index;
        sel_count  = sel_src ? reqB_count : reqA_count;
        sel_scale  = sel_src ? reqB_scale : reqA_scale;
        sel_jq     = sel_src ? reqB_jq    : reqA_jq;
        idx_d      = idx_q + 48'd1;
        rem_d      = rem_q - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            base_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            scale_q <= '0;
            jq_q    <= 1'b0;
            src_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        base_q  <= sel_base;
                        idx_q   <= sel_index;
                        rem_q   <= sel_count;
                        scale_q <= sel_scale;
                        jq_q    <= sel_jq;
                        src_q   <= sel_src;
                        if (sel_count == '0) begin
                            rr_q <= ~sel_src;
                        end else begin
                            state_q <= RUN;
                            addr_q  <= calc_addr(sel_base, sel_index, sel_scale, sel_jq);
                            valid_q <= 1'b1;
                            last_q  <= (sel_count == CNT_W'(1));
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (rem_q != CNT_W'(1)) begin
                            idx_q  <= idx_d;
                            rem_q  <= rem_d;
                            addr_q <= calc_addr(base_q, idx_d, scale_q, jq_q);
                            last_q <= (rem_q == CNT_W'(2));
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            rr_q    <= ~src_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_src   = src_q;
    assign out_last  = last_q;
    assign busy      = (state_q == RUN);

endmodule
